micro_hash_engine: RTL and testbench

Parametrised, handshaked successor of the micro-hash core, sitting between the block concatenator and the system controller. Accepts one BLOCK_BYTES-byte block per job over a valid/ready interface, expands it to ROUNDS message words, runs ROUNDS compression rounds from the fixed IV, and returns a 3-byte hash with a target-compare `hit` flag. Each job starts from the IV, so back-to-back jobs are independent.

---
 rtl/micro_hash_pkg.sv | 35 +++
 rtl/micro_hash_round.sv | 28 ++
 rtl/micro_hash_engine.sv | 202 ++++++++++++++++++++
 tb/tb_micro_hash_engine.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/micro_hash_pkg.sv
// micro_hash_pkg: shared constants, types and helpers for the micro-hash engine.
// Holds the fixed IV, the two round-constant sets, the message-expansion tap
// offsets and the engine state encoding.
package micro_hash_pkg;

    typedef logic [7:0] byte_t;

    // Fixed initial chaining value; every job restarts from here
    localparam byte_t H0_IV = 8'h01;
    localparam byte_t H1_IV = 8'h89;
    localparam byte_t H2_IV = 8'hfe;

    // Round constants: set 0 for early rounds, set 1 for late rounds
    localparam byte_t K0 = 8'h99;
    localparam byte_t K1 = 8'ha1;

    // Message-expansion tap offsets: W[i] = W[i-A] | (W[i-B] ^ W[i-C])
    localparam int TAP_A = 3;
    localparam int TAP_B = 9;
    localparam int TAP_C = 14;

    typedef enum logic [2:0] {
        IDLE,
        EXPAND,
        ROUND,
        FINAL,
        OUT
    } state_t;

    // One expanded message word from its three taps
    function automatic byte_t expand_word(input byte_t w_a, input byte_t w_b, input byte_t w_c);
        return w_a | (w_b ^ w_c);
    endfunction

endpackage

// File: rtl/micro_hash_round.sv
// micro_hash_round: one compression round of the micro-hash, purely combinational.
// late_round selects the second constant set and swaps the XOR mix for an OR.
module micro_hash_round
    import micro_hash_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] c,
    input  logic [7:0] w,
    input  logic       late_round,
    output logic [7:0] a_next,
    output logic [7:0] b_next,
    output logic [7:0] c_next
);

    logic [7:0] k;
    logic [7:0] x;

    // Round function: rotate the state words and fold mix + constant + message into c
    always_comb begin
        k      = late_round ? K1 : K0;
        x      = late_round ? (a | b) : (a ^ b);
        a_next = b ^ c;
        b_next = {c[3:0], 4'h0};
        c_next = x + k + w;
    end

endmodule

// File: rtl/micro_hash_engine.sv
// micro_hash_engine: handshaked micro-hash core.
// Accepts one BLOCK_BYTES-byte block, expands it to ROUNDS words (one per cycle),
// runs ROUNDS compression rounds from the fixed IV (one per cycle), adds the IV
// back in and holds the 3-byte hash until the consumer takes it.
// Optional feature macro: MICRO_HASH_TARGET_CHECK_EN
//   defined   : hit compares the low TARGET_BYTES hash bytes against the sampled
//               target and hash_out is zeroed whenever hit=0 (legacy gating).
//   undefined : target is ignored, hit=1 with every result, hash_out is raw.
module micro_hash_engine
    import micro_hash_pkg::*;
#(
    parameter int BLOCK_BYTES  = 16,
    parameter int ROUNDS       = 32,
    parameter int K_SPLIT      = 17,
    parameter int TARGET_BYTES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BLOCK_BYTES-1:0][7:0] block,
    input  logic [7:0]                  target,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [2:0][7:0]             hash_out,
    output logic                        hit,
    output logic                        busy
);

    localparam int IW         = $clog2(ROUNDS);
    localparam bit HAS_EXPAND = (ROUNDS > BLOCK_BYTES);

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   cnt;
    logic            cnt_last;
    logic            accept;
    logic            late_round;
    byte_t           w [ROUNDS];
    byte_t           a_q;
    byte_t           b_q;
    byte_t           c_q;
    logic [7:0]      a_n;
    logic [7:0]      b_n;
    logic [7:0]      c_n;
    logic [2:0][7:0] raw_hash;
    logic [2:0][7:0] hash_next;
    logic            hit_calc;

    assign accept     = in_valid && in_ready;
    assign cnt_last   = (int'(cnt) == ROUNDS - 1);
    assign late_round = (int'(cnt) >= K_SPLIT);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: expansion (if any) and rounds each run until the counter hits the last index
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = HAS_EXPAND ? EXPAND : ROUND;
            EXPAND:  if (cnt_last) state_next = ROUND;
            ROUND:   if (cnt_last) state_next = FINAL;
            FINAL:   state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake and status outputs; in_ready stays low while reset is held
    always_comb begin
        in_ready  = reset && (state == IDLE);
        busy      = (state != IDLE);
        out_valid = (state == OUT);
    end

    // Message schedule: capture the block on accept, then append one expanded word per EXPAND cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            for (int i = 0; i < ROUNDS; i++) begin
                w[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        for (int i = 0; i < BLOCK_BYTES; i++) begin
                            w[i] <= block[i];
                        end
                        for (int i = BLOCK_BYTES; i < ROUNDS; i++) begin
                            w[i] <= '0;
                        end
                        cnt <= HAS_EXPAND ? IW'(BLOCK_BYTES) : '0;
                    end
                end
                EXPAND: begin
                    w[cnt] <= expand_word(w[cnt - IW'(TAP_A)],
                                          w[cnt - IW'(TAP_B)],
                                          w[cnt - IW'(TAP_C)]);
                    cnt    <= cnt_last ? '0 : cnt + IW'(1);
                end
                ROUND: begin
                    cnt <= cnt_last ? '0 : cnt + IW'(1);
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    micro_hash_round u_round (
        .a          (a_q),
        .b          (b_q),
        .c          (c_q),
        .w          (w[cnt]),
        .late_round (late_round),
        .a_next     (a_n),
        .b_next     (b_n),
        .c_next     (c_n)
    );

    // Working state: load the IV on accept so each job is independent, advance one round per ROUND cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
        end else if (accept) begin
            a_q <= H0_IV;
            b_q <= H1_IV;
            c_q <= H2_IV;
        end else if (state == ROUND) begin
            a_q <= a_n;
            b_q <= b_n;
            c_q <= c_n;
        end
    end

    // Feed-forward: add the IV back onto the final working state, packed {H0,H1,H2}
    always_comb begin
        raw_hash[2] = H0_IV + a_q;
        raw_hash[1] = H1_IV + b_q;
        raw_hash[0] = H2_IV + c_q;
    end

`ifdef MICRO_HASH_TARGET_CHECK_EN
    byte_t target_q;

    // Target is sampled with the block so later changes do not affect this job
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            target_q <= '0;
        end else if (accept) begin
            target_q <= target;
        end
    end

    // Every compared low byte must be strictly below the target; failures zero the hash
    always_comb begin
        hit_calc = 1'b1;
        for (int j = 0; j < TARGET_BYTES; j++) begin
            if (raw_hash[j] >= target_q) begin
                hit_calc = 1'b0;
            end
        end
        hash_next = hit_calc ? raw_hash : '0;
    end
`else
    logic unused_target;
    localparam int unused_target_bytes = TARGET_BYTES;
    assign unused_target = ^target;

    // Without the compare every result is reported as a hit with the raw hash
    always_comb begin
        hit_calc  = 1'b1;
        hash_next = raw_hash;
    end
`endif

    // Result registers: load in FINAL, hold through OUT, clear on the consumer handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hash_out <= '0;
            hit      <= 1'b0;
        end else if (state == FINAL) begin
            hash_out <= hash_next;
            hit      <= hit_calc;
        end else if (state == OUT && out_ready) begin
            hash_out <= '0;
            hit      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_micro_hash_engine.sv
// tb_micro_hash_engine: scoreboard bench for micro_hash_engine.
// Stimulus pushes the model's expected result on every accepted block; an
// independent monitor pops and compares whenever out_valid rises.
module tb_micro_hash_engine;

    localparam int BB      = 16;
    localparam int R       = 32;
    localparam int KS      = 17;
    localparam int TBYTES  = 2;
    localparam int LATENCY = (R - BB) + R + 1;

    typedef logic [BB-1:0][7:0] block_t;

    typedef struct {
        logic [23:0] hash;
        logic        hit;
        int          acc;
    } exp_t;

    localparam block_t BLK0 = {8'h3c, 8'h87, 8'hed, 8'hfd, 8'h24, 8'h33, 8'h1f, 8'h6b,
                               8'h6c, 8'h9e, 8'hca, 8'h40, 8'h2f, 8'h9f, 8'h7d, 8'h39};
    localparam block_t BLK1 = 128'h00112233445566778899aabbccddeeff;
    localparam block_t BLK2 = 128'hdeadbeef0123456789abcdeffedcba98;
    localparam block_t BLK3 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    block_t          block;
    logic [7:0]      target;
    logic            out_valid;
    logic            out_ready;
    logic [2:0][7:0] hash_out;
    logic            hit;
    logic            busy;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    logic prev_valid  = 1'b0;
    exp_t mon_e;

    micro_hash_engine #(
        .BLOCK_BYTES  (BB),
        .ROUNDS       (R),
        .K_SPLIT      (KS),
        .TARGET_BYTES (TBYTES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .block     (block),
        .target    (target),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .hash_out  (hash_out),
        .hit       (hit),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: straight-line expansion then ROUNDS rounds from the IV
    function automatic exp_t model(input block_t blk, input logic [7:0] tgt);
        logic [7:0]  w [R];
        logic [7:0]  a, b, c, na, nb, nc, k, x;
        logic [23:0] h;
        exp_t        e;
        for (int i = 0; i < BB; i++) w[i] = blk[i];
        for (int i = BB; i < R; i++) w[i] = w[i-3] | (w[i-9] ^ w[i-14]);
        a = 8'h01; b = 8'h89; c = 8'hfe;
        for (int t = 0; t < R; t++) begin
            if (t < KS) begin k = 8'h99; x = a ^ b; end
            else        begin k = 8'ha1; x = a | b; end
            na = b ^ c;
            nb = c << 4;
            nc = x + k + w[t];
            a = na; b = nb; c = nc;
        end
        h = {8'h01 + a, 8'h89 + b, 8'hfe + c};
        e.hash = h;
        e.hit  = 1'b1;
        e.acc  = 0;
`ifdef MICRO_HASH_TARGET_CHECK_EN
        for (int j = 0; j < TBYTES; j++) begin
            if (h[j*8 +: 8] >= tgt) e.hit = 1'b0;
        end
        if (!e.hit) e.hash = '0;
`else
        if (tgt != tgt) e.acc = 1;
`endif
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Offer a block and wait (bounded) for acceptance; expected result is queued at the accepting edge
    task automatic applyStimulus(input block_t blk, input logic [7:0] tgt);
        exp_t e;
        bit   got;
        got = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        block    = blk;
        target   = tgt;
        for (int n = 0; n < 200 && !got; n++) begin
            if (in_ready) begin
                got   = 1'b1;
                e     = model(blk, tgt);
                e.acc = cyc;
                sb.push_back(e);
                @(posedge clk);
                #1 in_valid = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        if (!got) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end
    endtask

    task automatic waitDrain(input int budget);
        for (int n = 0; n < budget && sb.size() != 0; n++) @(negedge clk);
        checkOutput("queue_drained", sb.size(), 32'd0);
    endtask

    // Monitor: compare hash, hit and latency the first cycle a result is presented
    always @(negedge clk) begin
        if (!reset) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("hash", hash_out, mon_e.hash);
                    checkOutput("hit", hit, mon_e.hit);
                    checkOutput("latency", cyc - mon_e.acc - 1, LATENCY);
                end
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e_bp;
        bit   seen;
        in_valid  = 1'b0;
        block     = '0;
        target    = '0;
        out_ready = 1'b1;
        reset     = 1'b0;

        // Reset then idle
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 32'd0);
        checkOutput("rst_busy", busy, 32'd0);
        checkOutput("rst_out_valid", out_valid, 32'd0);
        checkOutput("rst_hash", hash_out, 32'd0);
        checkOutput("rst_hit", hit, 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("idle_in_ready", in_ready, 32'd1);

        // Default vector, permissive and zero target
        applyStimulus(BLK0, 8'hff);
        waitDrain(100);
        applyStimulus(BLK0, 8'h00);
        waitDrain(100);

        // Backpressure: hold the result for 10 cycles, try to sneak in a second block
        out_ready = 1'b0;
        applyStimulus(BLK1, 8'h80);
        e_bp = model(BLK1, 8'h80);
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            seen = out_valid;
        end
        checkOutput("bp_out_valid_seen", seen, 32'd1);
        for (int n = 0; n < 10; n++) begin
            if (n == 2) begin in_valid = 1'b1; block = BLK2; end
            if (n == 6) in_valid = 1'b0;
            checkOutput("bp_hash_hold", hash_out, e_bp.hash);
            checkOutput("bp_hit_hold", hit, e_bp.hit);
            checkOutput("bp_in_ready", in_ready, 32'd0);
            checkOutput("bp_out_valid", out_valid, 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("release_in_ready", in_ready, 32'd1);
        checkOutput("release_out_valid", out_valid, 32'd0);
        checkOutput("release_busy", busy, 32'd0);
        checkOutput("release_queue", sb.size(), 32'd0);

        // Back-to-back independent jobs
        applyStimulus(BLK2, 8'h80);
        applyStimulus(BLK3, 8'h40);
        waitDrain(200);

        // Reset mid-job at around round 10
        applyStimulus(BLK1, 8'hff);
        repeat (26) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("abort_out_valid", out_valid, 32'd0);
        checkOutput("abort_busy", busy, 32'd0);
        checkOutput("abort_in_ready", in_ready, 32'd0);
        checkOutput("abort_hash", hash_out, 32'd0);
        checkOutput("abort_hit", hit, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("post_abort_in_ready", in_ready, 32'd1);
        applyStimulus(BLK3, 8'hff);
        waitDrain(100);

        repeat (5) @(negedge clk);
        checkOutput("final_queue_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
